// File: rtl/chan_sequencer_pkg.sv
// Endpoint map and reset-init values shared by the config-bus blocks.
// The sequencer's enable-mask and overrun-clear endpoints are defined here.
package chan_sequencer_pkg;

  // Scan FSM states.
  typedef enum logic [0:0] {
    StIdle,
    StScan
  } seq_state_e;

  // Config endpoint addresses for the channel sequencer.
  localparam logic [15:0] SEQ_EN_ADDR  = 16'h0030;
  localparam logic [15:0] SEQ_CLR_ADDR = 16'h0031;

  // Reset value of the per-channel enable mask. It is wide enough for any
  // supported channel count; the sequencer takes the low N_CHAN bits.
  localparam logic [63:0] SEQ_EN_INIT = '1;

  // Increment an 8-bit event counter, holding it at full scale.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/chan_sequencer.sv
// Channel sequencer: latches one frame of packed ADC samples and serialises
// it as a dv/chan/data stream, one channel slot per clock. Channels that are
// masked off still consume their slot so every scan is exactly N_CHAN cycles.
module chan_sequencer
  import chan_sequencer_pkg::*;
#(
  parameter int unsigned W_CHAN    = 5,
  parameter int unsigned N_CHAN    = 20,
  parameter int unsigned W_DATA    = 18,
  parameter int unsigned W_WR_ADDR = 16,
  parameter int unsigned W_WR_CHAN = 5,
  parameter int unsigned W_WR_DATA = 49
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     frame_in,
  input  logic [N_CHAN*W_DATA-1:0] adc_data_in,
  input  logic                     wr_en,
  input  logic [W_WR_ADDR-1:0]     wr_addr,
  input  logic [W_WR_CHAN-1:0]     wr_chan,
  input  logic [W_WR_DATA-1:0]     wr_data,
  output logic                     dv_out,
  output logic [W_CHAN-1:0]        chan_out,
  output logic signed [W_DATA-1:0] data_out,
  output logic                     busy_out,
  output logic [7:0]               ovr_cnt_out
);

  localparam logic [W_CHAN-1:0] LAST_IDX = W_CHAN'(N_CHAN - 1);

  // Scan control
  seq_state_e        state_q, state_d;
  logic [W_CHAN-1:0] idx_q, idx_d;

  // Frame buffer and the mask snapshot taken with it
  logic signed [W_DATA-1:0] buf_q [N_CHAN];
  logic signed [W_DATA-1:0] buf_d [N_CHAN];
  logic [N_CHAN-1:0]        snap_q, snap_d;

  // Live configuration and status
  logic [N_CHAN-1:0] en_mask_q, en_mask_d;
  logic [7:0]        ovr_q, ovr_d;

  // Registered output stream
  logic                     dv_q, dv_d;
  logic [W_CHAN-1:0]        chan_q, chan_d;
  logic signed [W_DATA-1:0] data_q, data_d;

  logic at_last;
  logic accept;
  logic drop;
  logic en_wr;
  logic clr_wr;

  // Only bit 0 of the config value is meaningful to this block.
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data[W_WR_DATA-1:1];

  // Frame acceptance: idle, or the last slot of a scan so scans chain with no gap.
  always_comb begin
    at_last = (state_q == StScan) && (idx_q == LAST_IDX);
    accept  = frame_in && ((state_q == StIdle) || at_last);
    drop    = frame_in && (state_q == StScan) && !at_last;
    en_wr   = wr_en && (wr_addr == W_WR_ADDR'(SEQ_EN_ADDR)) && (32'(wr_chan) < N_CHAN);
    clr_wr  = wr_en && (wr_addr == W_WR_ADDR'(SEQ_CLR_ADDR));
  end

  // FSM next state and scan index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (accept) begin
      state_d = StScan;
      idx_d   = '0;
    end else if (at_last) begin
      state_d = StIdle;
      idx_d   = '0;
    end else if (state_q == StScan) begin
      idx_d = idx_q + W_CHAN'(1);
    end
  end

  // Output stream: emit the current slot; disabled slots keep chan/data stable.
  always_comb begin
    dv_d   = 1'b0;
    chan_d = chan_q;
    data_d = data_q;
    if (state_q == StScan) begin
      dv_d = snap_q[idx_q];
      if (snap_q[idx_q]) begin
        chan_d = idx_q;
        data_d = buf_q[idx_q];
      end
    end
  end

  // Frame capture. The snapshot uses the mask as it stood before this edge,
  // so a coincident mask write only affects later frames.
  always_comb begin
    buf_d  = buf_q;
    snap_d = snap_q;
    if (accept) begin
      for (int k = 0; k < int'(N_CHAN); k++) begin
        buf_d[k] = adc_data_in[k*W_DATA +: W_DATA];
      end
      snap_d = en_mask_q;
    end
  end

  // Config writes and the dropped-frame counter; a clear beats a same-edge drop.
  always_comb begin
    en_mask_d = en_mask_q;
    ovr_d     = ovr_q;
    if (en_wr) begin
      en_mask_d[wr_chan] = wr_data[0];
    end
    if (clr_wr) begin
      ovr_d = '0;
    end else if (drop) begin
      ovr_d = sat_inc8(ovr_q);
    end
  end

  // State, buffer and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      for (int k = 0; k < int'(N_CHAN); k++) begin
        buf_q[k] <= '0;
      end
      snap_q    <= '0;
      en_mask_q <= SEQ_EN_INIT[N_CHAN-1:0];
      ovr_q     <= '0;
      dv_q      <= 1'b0;
      chan_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      snap_q    <= snap_d;
      en_mask_q <= en_mask_d;
      ovr_q     <= ovr_d;
      dv_q      <= dv_d;
      chan_q    <= chan_d;
      data_q    <= data_d;
    end
  end

  assign dv_out      = dv_q;
  assign chan_out    = chan_q;
  assign data_out    = data_q;
  assign busy_out    = (state_q == StScan);
  assign ovr_cnt_out = ovr_q;

endmodule

// File: tb/tb_chan_sequencer.sv
// Bench for chan_sequencer: cycle-level reference model plus a scoreboard of
// expected (chan, data) pairs pushed on frame acceptance and popped on dv_out.
module tb_chan_sequencer;
  import chan_sequencer_pkg::*;

  localparam int W_CHAN    = 5;
  localparam int N_CHAN    = 20;
  localparam int W_DATA    = 18;
  localparam int W_WR_ADDR = 16;
  localparam int W_WR_CHAN = 5;
  localparam int W_WR_DATA = 49;

  logic                     clk_in = 1'b0;
  logic                     rst_n_in;
  logic                     frame_in;
  logic [N_CHAN*W_DATA-1:0] adc_data_in;
  logic                     wr_en;
  logic [W_WR_ADDR-1:0]     wr_addr;
  logic [W_WR_CHAN-1:0]     wr_chan;
  logic [W_WR_DATA-1:0]     wr_data;
  logic                     dv_out;
  logic [W_CHAN-1:0]        chan_out;
  logic signed [W_DATA-1:0] data_out;
  logic                     busy_out;
  logic [7:0]               ovr_cnt_out;

  chan_sequencer dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .frame_in    (frame_in),
    .adc_data_in (adc_data_in),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_chan     (wr_chan),
    .wr_data     (wr_data),
    .dv_out      (dv_out),
    .chan_out    (chan_out),
    .data_out    (data_out),
    .busy_out    (busy_out),
    .ovr_cnt_out (ovr_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [W_CHAN-1:0]        chan;
    logic signed [W_DATA-1:0] data;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;
  int m_drops = 0;

  // Reference model state
  logic              m_busy;
  int                m_idx;
  logic [N_CHAN-1:0] m_snap;
  logic [N_CHAN-1:0] m_mask;
  int                m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_idx  = 0;
    m_snap = '0;
    m_mask = '1;
    m_ovr  = 0;
    sb.delete();
  endtask

  // Advance the model for the inputs now driven, clock once, then check.
  task automatic tick();
    logic m_last, acc, drp, exp_dv;
    exp_t e;
    m_last = m_busy && (m_idx == N_CHAN - 1);
    acc    = frame_in && (!m_busy || m_last);
    drp    = frame_in && m_busy && !m_last;
    exp_dv = m_busy && m_snap[m_idx];
    if (acc) begin
      for (int k = 0; k < N_CHAN; k++) begin
        if (m_mask[k]) sb.push_back('{chan: W_CHAN'(k), data: adc_data_in[k*W_DATA +: W_DATA]});
      end
      m_snap = m_mask;
    end
    if (drp) m_drops++;
    if (wr_en && wr_addr == SEQ_CLR_ADDR) m_ovr = 0;
    else if (drp && m_ovr != 255) m_ovr++;
    if (wr_en && wr_addr == SEQ_EN_ADDR && int'(wr_chan) < N_CHAN) m_mask[wr_chan] = wr_data[0];
    if (acc) begin
      m_busy = 1'b1;
      m_idx  = 0;
    end else if (m_last) begin
      m_busy = 1'b0;
      m_idx  = 0;
    end else if (m_busy) begin
      m_idx++;
    end
    @(posedge clk_in);
    #1;
    chk("dv_out", dv_out, exp_dv);
    chk("busy_out", busy_out, m_busy);
    chk("ovr_cnt_out", ovr_cnt_out, m_ovr);
    if (dv_out === 1'b1) begin
      pulses++;
      n_chk++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow: observed dv with chan %0d, expected no output", chan_out);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_chan", chan_out, e.chan);
        chk("sb_data", data_out, e.data);
      end
    end
  endtask

  task automatic wr(input logic [15:0] addr, input int ch, input logic d);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_chan = W_WR_CHAN'(ch);
    wr_data = W_WR_DATA'(d);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic set_adc(input int base, input int step);
    for (int k = 0; k < N_CHAN; k++) adc_data_in[k*W_DATA +: W_DATA] = W_DATA'(base + step * k);
  endtask

  initial begin
    rst_n_in    = 1'b1;
    frame_in    = 1'b0;
    adc_data_in = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_chan     = '0;
    wr_data     = '0;
    model_reset();

    // Power-on reset values
    #2 rst_n_in = 1'b0;
    #1;
    chk("rst_dv", dv_out, 0);
    chk("rst_chan", chan_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_ovr", ovr_cnt_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Full scan, all channels enabled, sample k = 3k
    set_adc(0, 3);
    frame_in = 1'b1;
    tick();
    frame_in = 1'b0;
    chk("t1_dv_edge0", dv_out, 0);
    pulses = 0;
    for (int e = 1; e <= N_CHAN; e++) begin
      tick();
      if (e == N_CHAN) begin
        chk("t1_last_chan", chan_out, 19);
        chk("t1_last_data", data_out, 57);
        chk("t1_busy_end", busy_out, 0);
      end
    end
    chk("t1_pulses", pulses, 20);
    tick();
    chk("t1_dv_idle", dv_out, 0);

    // Channels 3 and 7 masked off; slots still consumed
    wr(SEQ_EN_ADDR, 3, 1'b0);
    wr(SEQ_EN_ADDR, 7, 1'b0);
    wr(SEQ_EN_ADDR, 25, 1'b0);  // out of range, ignored
    set_adc(50, -7);
    frame_in = 1'b1;
    tick();
    frame_in = 1'b0;
    pulses = 0;
    for (int e = 1; e <= N_CHAN; e++) begin
      tick();
      if (e == 4) begin
        chk("t2_hold_chan", chan_out, 2);
        chk("t2_hold_data", data_out, 36);
      end
      if (e == N_CHAN - 1) chk("t2_busy_mid", busy_out, 1);
    end
    chk("t2_pulses", pulses, 18);
    chk("t2_busy_end", busy_out, 0);
    wr(SEQ_EN_ADDR, 3, 1'b1);
    wr(SEQ_EN_ADDR, 7, 1'b1);

    // Overrun mid-scan, then a back-to-back frame on the last slot
    wr(SEQ_CLR_ADDR, 0, 1'b0);
    set_adc(1, 2);
    frame_in = 1'b1;
    tick();
    for (int e = 1; e <= 2 * N_CHAN; e++) begin
      frame_in = (e == 5) || (e == N_CHAN);
      if (e == N_CHAN) set_adc(1000, -1);
      tick();
      if (e == 5) chk("t3_ovr_one", ovr_cnt_out, 1);
      if (e == N_CHAN) chk("t3_busy_chain", busy_out, 1);
      if (e == N_CHAN + 1) begin
        chk("t3_b2b_dv", dv_out, 1);
        chk("t3_b2b_chan", chan_out, 0);
        chk("t3_b2b_data", data_out, 1000);
      end
    end
    frame_in = 1'b0;
    chk("t3_busy_end", busy_out, 0);
    chk("t3_sb_empty", sb.size(), 0);

    // Saturating overrun count, then clear coincident with a drop
    m_drops = 0;
    frame_in = 1'b1;
    for (int i = 0; i < 2000 && m_drops < 300; i++) begin
      for (int k = 0; k < N_CHAN; k++) adc_data_in[k*W_DATA +: W_DATA] = W_DATA'($urandom);
      tick();
    end
    chk("t4_drops", m_drops, 300);
    chk("t4_ovr_sat", ovr_cnt_out, 255);
    for (int i = 0; i < 50 && !(m_busy && m_idx != N_CHAN - 1); i++) tick();
    wr(SEQ_CLR_ADDR, 0, 1'b0);
    chk("t4_clr_wins", ovr_cnt_out, 0);
    frame_in = 1'b0;
    for (int i = 0; i < 2 * N_CHAN && m_busy; i++) tick();
    tick();
    chk("t4_sb_empty", sb.size(), 0);

    // Mask write on the acceptance edge applies from the next frame
    set_adc(-9, 4);
    frame_in = 1'b1;
    wr(SEQ_EN_ADDR, 0, 1'b0);
    frame_in = 1'b0;
    tick();
    chk("t5_ch0_now_dv", dv_out, 1);
    chk("t5_ch0_now_chan", chan_out, 0);
    repeat (N_CHAN - 1) tick();
    set_adc(7, 5);
    frame_in = 1'b1;
    tick();
    frame_in = 1'b0;
    tick();
    chk("t5_ch0_next_dv", dv_out, 0);
    tick();
    chk("t5_ch1_dv", dv_out, 1);
    chk("t5_ch1_chan", chan_out, 1);
    repeat (N_CHAN - 1) tick();
    chk("t5_sb_empty", sb.size(), 0);

    // Reset mid-scan at idx 10 (ch 12 masked so the mask restore is visible)
    wr(SEQ_EN_ADDR, 12, 1'b0);
    set_adc(20, 1);
    frame_in = 1'b1;
    tick();
    frame_in = 1'b0;
    repeat (10) tick();
    chk("t6_pre_dv", dv_out, 1);
    #3 rst_n_in = 1'b0;
    #1;
    chk("t6_async_dv", dv_out, 0);
    chk("t6_async_busy", busy_out, 0);
    chk("t6_async_chan", chan_out, 0);
    chk("t6_async_data", data_out, 0);
    model_reset();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    pulses = 0;
    repeat (N_CHAN + 5) tick();
    chk("t6_no_pulses", pulses, 0);
    set_adc(300, -11);
    frame_in = 1'b1;
    tick();
    frame_in = 1'b0;
    chk("t6_first_accept", busy_out, 1);
    repeat (N_CHAN) tick();
    chk("t6_mask_restored", pulses, 20);
    chk("t6_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
